// File: rtl/sha_pkg.sv
// Shared types and constants for the SHA-256 message schedule expander.
package sha_pkg;

    typedef logic [31:0] word_t;

    localparam int NUM_WORDS   = 64;
    localparam int BLOCK_WORDS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/sha256_sigma.sv
// SHA-256 small sigma functions: sig0 of the W[t-15] operand, sig1 of the W[t-2] operand.
module sha256_sigma (
    input  logic [31:0] w15,
    input  logic [31:0] w2,
    output logic [31:0] sig0,
    output logic [31:0] sig1
);

    assign sig0 = {w15[6:0], w15[31:7]} ^ {w15[17:0], w15[31:18]} ^ (w15 >> 3);
    assign sig1 = {w2[16:0], w2[31:17]} ^ {w2[18:0], w2[31:19]} ^ (w2 >> 10);

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: expands one 512-bit block into W0..W63 in place.
// Define SHA256_SCHED_FAST_EN to compute two words per RUN edge instead of one.
//
// state | meaning
// IDLE  | waiting for start, w_out holds last result
// RUN   | writing W[t] (and W[t+1] in the fast build) each edge
// FIN   | one-cycle done pulse, start may reload immediately
module sha256_msg_sched
    import sha_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [511:0]  block_in,
    output logic          busy,
    output logic          done,
    output logic [2047:0] w_out
);

`ifdef SHA256_SCHED_FAST_EN
    localparam int LANES = 2;
`else
    localparam int LANES = 1;
`endif
    localparam logic [5:0] T_STEP = 6'(LANES);
    localparam logic [5:0] T_LAST = 6'(NUM_WORDS - LANES);

    state_t state, state_nxt;
    logic [5:0] t;
    word_t w [NUM_WORDS];
    logic [LANES-1:0][31:0] w_new;
    logic accept;

    assign accept = start && (state != RUN);

    // Lane l produces W[t+l]; its operands never depend on a word written in the same edge.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [5:0] tl;
        word_t s0, s1;
        assign tl = t + 6'(l);
        sha256_sigma u_sigma (
            .w15  (w[tl - 6'd15]),
            .w2   (w[tl - 6'd2]),
            .sig0 (s0),
            .sig1 (s1)
        );
        assign w_new[l] = s1 + w[tl - 6'd7] + s0 + w[tl - 6'd16];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (t == T_LAST) state_nxt = FIN;
            FIN:     state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == FIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            t <= '0;
            for (int i = 0; i < NUM_WORDS; i++) w[i] <= '0;
        end else if (accept) begin
            t <= 6'(BLOCK_WORDS);
            for (int i = 0; i < BLOCK_WORDS; i++) w[i] <= block_in[511 - 32*i -: 32];
            for (int i = BLOCK_WORDS; i < NUM_WORDS; i++) w[i] <= '0;
        end else if (state == RUN) begin
            t <= t + T_STEP;
            for (int l = 0; l < LANES; l++) w[t + 6'(l)] <= w_new[l];
        end
    end

    for (genvar i = 0; i < NUM_WORDS; i++) begin : g_out
        assign w_out[32*i +: 32] = w[i];
    end

endmodule
